// File: rtl/array_output_drain_pkg.sv
// Shared definitions for the systolic-array output path: drain FSM encoding and
// tile index sizing. Also imported by the upstream array controller.
package array_output_drain_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  // Minimum 1 bit so degenerate 1-entry tiles still get a legal index.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/drain_tile_mem.sv
// rows*cols x width tile register file: one row-wide write port, one
// single-word combinational read port addressed row-major.
module drain_tile_mem
  import array_output_drain_pkg::*;
#(
  parameter int width = 16,
  parameter int rows  = 4,
  parameter int cols  = 4,
  parameter int AW    = clog2(rows),
  parameter int IW    = clog2(rows * cols)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [cols*width-1:0] wdata,
  input  logic [IW-1:0]         raddr,
  output logic [width-1:0]      rdata
);

  logic [width-1:0] mem [rows*cols];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int r = 0; r < rows; r++) begin
        for (int c = 0; c < cols; c++) begin
          if (waddr == AW'(r)) mem[r*cols + c] <= wdata[c*width +: width];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/array_output_drain.sv
// Collects rows captures of the array outputs into a tile, then drains it one
// word per valid/ready handshake. Define ARRAY_DRAIN_RELU_EN to clamp negatives at capture.
module array_output_drain
  import array_output_drain_pkg::*;
#(
  parameter int width   = 16,
  parameter int decimal = 8,
  parameter int rows    = 4,
  parameter int cols    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap,
  input  logic [cols*width-1:0]    outs_array,
  output logic [width-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     ovf,
  output logic [$clog2(rows):0]    row_cnt
);

  localparam int N   = rows * cols;
  localparam int IW  = clog2(N);
  localparam int AW  = clog2(rows);
  localparam int RCW = $clog2(rows) + 1;

  // decimal only documents the fixed-point format; reject impossible formats.
  if (decimal >= width) begin : g_bad_decimal
    $error("decimal must be smaller than width");
  end

  // Handshake: a word transfers on any rising edge where out_valid && out_ready;
  // while out_valid && !out_ready, out_data/out_valid/out_last are held.
  drain_state_e         state, state_d;
  logic [IW-1:0]        idx, idx_d;
  logic [RCW-1:0]       row_cnt_d;
  logic [width-1:0]     data_d;
  logic                 last_d, ovf_d;
  logic                 mem_we;
  logic [IW-1:0]        rd_addr;
  logic [width-1:0]     rd_data;
  logic [cols*width-1:0] wdata;
  logic [width-1:0]     first_word;

  function automatic logic [width-1:0] clamp_word(input logic [width-1:0] w);
`ifdef ARRAY_DRAIN_RELU_EN
    return w[width-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  always_comb begin
    wdata = '0;
    for (int c = 0; c < cols; c++) begin
      wdata[c*width +: width] = clamp_word(outs_array[c*width +: width]);
    end
  end

  drain_tile_mem #(
    .width (width),
    .rows  (rows),
    .cols  (cols),
    .AW    (AW),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (row_cnt[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // With a single-row tile, word 0 is being written by the completing capture.
  assign first_word = (rows == 1) ? wdata[width-1:0] : rd_data;

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    row_cnt_d = row_cnt;
    data_d    = out_data;
    last_d    = out_last;
    ovf_d     = ovf;
    mem_we    = 1'b0;
    rd_addr   = '0;
    case (state)
      ST_FILL: begin
        if (cap) begin
          mem_we = 1'b1;
          if (row_cnt == RCW'(rows - 1)) begin
            state_d   = ST_DRAIN;
            row_cnt_d = '0;
            idx_d     = '0;
            data_d    = first_word;
            last_d    = (N == 1);
          end else begin
            row_cnt_d = row_cnt + RCW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (cap) ovf_d = 1'b1;
        if (out_ready) begin
          if (idx == IW'(N - 1)) begin
            state_d = ST_FILL;
            idx_d   = '0;
            last_d  = 1'b0;
          end else begin
            idx_d   = idx + IW'(1);
            rd_addr = idx + IW'(1);
            data_d  = rd_data;
            last_d  = ((idx + IW'(1)) == IW'(N - 1));
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FILL;
      idx      <= '0;
      row_cnt  <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      row_cnt  <= row_cnt_d;
      out_data <= data_d;
      out_last <= last_d;
      ovf      <= ovf_d;
    end
  end

  // busy doubles as the visible FSM state.
  assign out_valid = (state == ST_DRAIN);
  assign busy      = (state == ST_DRAIN);

endmodule
